// File: rtl/pipe_reg_if.sv
// Handshake bundle for pipe_reg: producer side (in_*), consumer side (out_*),
// flush, and the occupancy count.
interface pipe_reg_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  // Valid/ready: a word moves on an edge where valid & ready are both 1.
  // The sender holds valid and data stable until that edge; ready may change
  // combinationally with downstream state and with flush.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg.sv
// Elastic pipeline register: DEPTH valid-tagged stages, bubbles collapse under
// backpressure, flush drops every in-flight word at the next edge.
module pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input logic       clkrst_core_clk,
  input logic       clkrst_core_rst_n,
  pipe_reg_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] u;
  logic [CW-1:0]    cnt;

  // A stage can load if it is empty or the stage after it can load too.
  always_comb begin
    logic acc;
    acc = bus.out_ready;
    r   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc  = ~v[i] | acc;
      r[i] = acc;
    end
  end

  always_comb begin
    u    = '0;
    u[0] = bus.in_valid & ~bus.flush;
    for (int i = 1; i < DEPTH; i++) begin
      u[i] = v[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             v_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_first
      assign up_data = bus.in_data;
    end else begin : g_rest
      assign up_data = d[i-1];
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
      if (!clkrst_core_rst_n) begin
        v_q <= 1'b0;
        d_q <= RESET_VAL;
      end else begin
        if (bus.flush) begin
          v_q <= 1'b0;
        end else if (r[i]) begin
          v_q <= u[i];
        end
        // Data only moves with a real word; flush leaves every d untouched.
        if (r[i] & u[i] & ~bus.flush) begin
          d_q <= up_data;
        end
      end
    end

    assign v[i] = v_q;
    assign d[i] = d_q;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CW'(v[i]);
    end
  end

  assign bus.in_ready  = r[0] & ~bus.flush;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];
  assign bus.count     = cnt;
endmodule
